// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register,
// IDCODE/BYPASS data registers and boundary-scan chain strobes.
module jtag_tap_ctrl #(
   parameter int unsigned IR_W   = 4,
   parameter logic [31:0] IDCODE = 32'h1000_0001
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tms,
   input  logic            tdi,
   output logic            tdo,
   output logic            tdo_en,
   input  logic            bsr_so,
   output logic            shift_dr,
   output logic            clk_dr,
   output logic            update_dr,
   output logic            mode,
   output logic [3:0]      tap_state,
   output logic [IR_W-1:0] ir
);

   localparam logic [3:0] TLR     = 4'hF;
   localparam logic [3:0] RTI     = 4'hC;
   localparam logic [3:0] SEL_DR  = 4'h7;
   localparam logic [3:0] CAP_DR  = 4'h6;
   localparam logic [3:0] SH_DR   = 4'h2;
   localparam logic [3:0] EX1_DR  = 4'h1;
   localparam logic [3:0] PAU_DR  = 4'h3;
   localparam logic [3:0] EX2_DR  = 4'h0;
   localparam logic [3:0] UPD_DR  = 4'h5;
   localparam logic [3:0] SEL_IR  = 4'h4;
   localparam logic [3:0] CAP_IR  = 4'hE;
   localparam logic [3:0] SH_IR   = 4'hA;
   localparam logic [3:0] EX1_IR  = 4'h9;
   localparam logic [3:0] PAU_IR  = 4'hB;
   localparam logic [3:0] EX2_IR  = 4'h8;
   localparam logic [3:0] UPD_IR  = 4'hD;

   localparam logic [IR_W-1:0] I_EXTEST = '0;
   localparam logic [IR_W-1:0] I_SAMPLE = IR_W'(1);
   localparam logic [IR_W-1:0] I_IDCODE = IR_W'(2);
   localparam logic [IR_W-1:0] I_CAPT   = IR_W'(1);

   logic [3:0]      state_q, state_d;
   logic [IR_W-1:0] ir_sr_q, ir_sr_d;
   logic [IR_W-1:0] ir_q, ir_d;
   logic [31:0]     id_q, id_d;
   logic            byp_q, byp_d;
   logic            sel_bsr, sel_id;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:     state_d = tms ? TLR    : RTI;
         RTI:     state_d = tms ? SEL_DR : RTI;
         SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
         SH_DR:   state_d = tms ? EX1_DR : SH_DR;
         EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
         PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
         EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
         UPD_DR:  state_d = tms ? SEL_DR : RTI;
         SEL_IR:  state_d = tms ? TLR    : CAP_IR;
         CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
         SH_IR:   state_d = tms ? EX1_IR : SH_IR;
         EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
         PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
         EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
         UPD_IR:  state_d = tms ? SEL_DR : RTI;
         default: state_d = TLR;
      endcase
   end

   // Unlisted opcodes fall through to the bypass register.
   assign sel_bsr = (ir_q == I_EXTEST) || (ir_q == I_SAMPLE);
   assign sel_id  = (ir_q == I_IDCODE);

   always_comb begin
      ir_sr_d = ir_sr_q;
      ir_d    = ir_q;
      id_d    = id_q;
      byp_d   = byp_q;
      if (state_q == CAP_IR) ir_sr_d = I_CAPT;
      if (state_q == SH_IR)  ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
      if (state_q == UPD_IR) ir_d = ir_sr_q;
      if (state_d == TLR)    ir_d = I_IDCODE;
      if (sel_id) begin
         if (state_q == CAP_DR) id_d = IDCODE;
         if (state_q == SH_DR)  id_d = {tdi, id_q[31:1]};
      end
      if (!sel_bsr && !sel_id) begin
         if (state_q == CAP_DR) byp_d = 1'b0;
         if (state_q == SH_DR)  byp_d = tdi;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TLR;
         ir_sr_q <= '0;
         ir_q    <= I_IDCODE;
         id_q    <= IDCODE;
         byp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_sr_q <= ir_sr_d;
         ir_q    <= ir_d;
         id_q    <= id_d;
         byp_q   <= byp_d;
      end
   end

   assign tap_state = state_q;
   assign ir        = ir_q;
   assign mode      = (ir_q == I_EXTEST);
   assign tdo_en    = (state_q == SH_IR) || (state_q == SH_DR);
   assign clk_dr    = sel_bsr &&
                      ((state_q == CAP_DR) || (state_q == SH_DR));
   assign shift_dr  = sel_bsr && (state_q == SH_DR);
   assign update_dr = sel_bsr && (state_q == UPD_DR);

   always_comb begin
      tdo = 1'b0;
      if (state_q == SH_IR)
         tdo = ir_sr_q[0];
      else if (state_q == SH_DR)
         tdo = sel_bsr ? bsr_so : (sel_id ? id_q[0] : byp_q);
   end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: FSM walk, IR load, IDCODE,
// BYPASS, boundary strobes and reset during a shift.
module tb_jtag_tap_ctrl;

   localparam logic [31:0] IDC = 32'h1000_0001;

   logic       clk = 1'b0;
   logic       rst, tms, tdi, bsr_so;
   logic       tdo, tdo_en, shift_dr, clk_dr, update_dr, mode;
   logic [3:0] tap_state;
   logic [3:0] ir;

   int checks = 0;
   int errors = 0;

   jtag_tap_ctrl #(.IR_W(4), .IDCODE(IDC)) dut (
      .clk(clk), .rst(rst), .tms(tms), .tdi(tdi),
      .tdo(tdo), .tdo_en(tdo_en), .bsr_so(bsr_so),
      .shift_dr(shift_dr), .clk_dr(clk_dr),
      .update_dr(update_dr), .mode(mode),
      .tap_state(tap_state), .ir(ir)
   );

   always #5 clk = ~clk;

   task automatic step(input logic t, input logic d);
      tms = t;
      tdi = d;
      @(posedge clk);
      #1;
   endtask

   // From RTI: shift code into IR, return to RTI; cap holds tdo bits.
   task automatic load_ir(input logic [3:0] code,
                          output logic [3:0] cap);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 4; i++) begin
         cap[i] = tdo;
         step(i == 3, code[i]);
      end
      step(1, 0); step(0, 0);
   endtask

   // From RTI: n-bit DR scan, return to RTI; flags any bsr strobe.
   task automatic dr_scan(input int n, input logic [31:0] din,
                          output logic [31:0] dout,
                          output logic strobe);
      dout = '0;
      strobe = 1'b0;
      step(1, 0); step(0, 0);
      strobe |= clk_dr | update_dr;
      step(0, 0);
      for (int i = 0; i < n; i++) begin
         dout[i] = tdo;
         strobe |= clk_dr | update_dr;
         step(i == n - 1, din[i]);
      end
      step(1, 0);
      strobe |= clk_dr | update_dr;
      step(0, 0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(1, 0); step(1, 0);
      checks++;
      if (tap_state !== 4'hF) begin
         errors++;
         $display("FAIL reset_state: got %h want F", tap_state);
      end
      checks++;
      if (ir !== 4'b0010) begin
         errors++;
         $display("FAIL reset_ir: got %b want 0010", ir);
      end
      checks++;
      if ({shift_dr, clk_dr, update_dr, mode, tdo_en, tdo} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outs: got %b want 000000",
                  {shift_dr, clk_dr, update_dr, mode, tdo_en, tdo});
      end
      rst = 1'b0;
   endtask

   task automatic test_walk;
      logic [19:0] tv = 20'b11111010111101001010;
      logic [3:0]  sv [20] = '{4'hC, 4'h7, 4'h6, 4'h1, 4'h3,
                               4'h3, 4'h0, 4'h2, 4'h1, 4'h5,
                               4'h7, 4'h4, 4'hE, 4'h9, 4'hB,
                               4'h8, 4'hD, 4'h7, 4'h4, 4'hF};
      for (int i = 0; i < 20; i++) begin
         step(tv[i], 0);
         checks++;
         if (tap_state !== sv[i]) begin
            errors++;
            $display("FAIL walk_%0d: got %h want %h",
                     i, tap_state, sv[i]);
         end
         if (i == 17) begin
            checks++;
            if (ir !== 4'b0001) begin
               errors++;
               $display("FAIL walk_ir_capt: got %b want 0001", ir);
            end
         end
      end
   endtask

   task automatic test_tlr_five;
      step(0, 0);
      for (int i = 0; i < 5; i++) step(1, 0);
      checks++;
      if (tap_state !== 4'hF || ir !== 4'b0010) begin
         errors++;
         $display("FAIL tlr_from_rti: got %h/%b want F/0010",
                  tap_state, ir);
      end
      step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 5; i++) step(1, 0);
      checks++;
      if (tap_state !== 4'hF || ir !== 4'b0010) begin
         errors++;
         $display("FAIL tlr_from_shir: got %h/%b want F/0010",
                  tap_state, ir);
      end
   endtask

   task automatic test_extest;
      logic [3:0] cap;
      step(0, 0);
      load_ir(4'b0000, cap);
      checks++;
      if (cap !== 4'b0001) begin
         errors++;
         $display("FAIL extest_tdo: got %b want 0001", cap);
      end
      checks++;
      if (ir !== 4'b0000 || mode !== 1'b1) begin
         errors++;
         $display("FAIL extest_ir: got %b/%b want 0000/1", ir, mode);
      end
   endtask

   task automatic test_idcode;
      logic [31:0] dout;
      logic        strobe;
      for (int i = 0; i < 5; i++) step(1, 0);
      step(0, 0);
      dr_scan(32, 32'h0, dout, strobe);
      checks++;
      if (dout !== IDC) begin
         errors++;
         $display("FAIL idcode_scan: got %h want %h", dout, IDC);
      end
      checks++;
      if (strobe !== 1'b0) begin
         errors++;
         $display("FAIL idcode_strobe: got %b want 0", strobe);
      end
   endtask

   task automatic test_bypass;
      logic [3:0]  codes [2] = '{4'b1111, 4'b0110};
      logic [3:0]  cap;
      logic [31:0] dout;
      logic        strobe;
      for (int k = 0; k < 2; k++) begin
         load_ir(codes[k], cap);
         checks++;
         if (ir !== codes[k]) begin
            errors++;
            $display("FAIL bypass_ir: got %b want %b", ir, codes[k]);
         end
         dr_scan(8, 32'hA5, dout, strobe);
         checks++;
         if (dout[7:0] !== 8'h4A || strobe !== 1'b0) begin
            errors++;
            $display("FAIL bypass_scan_%b: got %h/%b want 4a/0",
                     codes[k], dout[7:0], strobe);
         end
      end
   endtask

   task automatic test_sample;
      logic [3:0] cap;
      logic [3:0] pat = 4'b1011;
      load_ir(4'b0001, cap);
      checks++;
      if (mode !== 1'b0) begin
         errors++;
         $display("FAIL sample_mode: got %b want 0", mode);
      end
      step(1, 0);
      step(0, 0);
      checks++;
      if ({clk_dr, shift_dr, tdo_en} !== 3'b100) begin
         errors++;
         $display("FAIL sample_capdr: got %b want 100",
                  {clk_dr, shift_dr, tdo_en});
      end
      step(0, 0);
      for (int i = 0; i < 4; i++) begin
         bsr_so = pat[i];
         #1;
         checks++;
         if ({tdo, clk_dr, shift_dr, tdo_en} !== {pat[i], 3'b111}) begin
            errors++;
            $display("FAIL sample_shdr_%0d: got %b want %b", i,
                     {tdo, clk_dr, shift_dr, tdo_en}, {pat[i], 3'b111});
         end
         step(i == 3, 0);
      end
      checks++;
      if ({clk_dr, update_dr} !== 2'b00) begin
         errors++;
         $display("FAIL sample_ex1: got %b want 00", {clk_dr, update_dr});
      end
      step(1, 0);
      checks++;
      if ({update_dr, mode} !== 2'b10) begin
         errors++;
         $display("FAIL sample_upd: got %b want 10", {update_dr, mode});
      end
      step(0, 0);
      checks++;
      if (update_dr !== 1'b0) begin
         errors++;
         $display("FAIL sample_upd_pulse: got %b want 0", update_dr);
      end
   endtask

   task automatic test_reset_mid_shift;
      logic [3:0] cap;
      load_ir(4'b0000, cap);
      bsr_so = 1'b1;
      step(1, 0); step(0, 0); step(0, 0);
      checks++;
      if ({shift_dr, mode, tdo} !== 3'b111) begin
         errors++;
         $display("FAIL rstmid_pre: got %b want 111",
                  {shift_dr, mode, tdo});
      end
      step(0, 1);
      rst = 1'b1;
      step(0, 0);
      rst = 1'b0;
      checks++;
      if (tap_state !== 4'hF || ir !== 4'b0010) begin
         errors++;
         $display("FAIL rstmid_state: got %h/%b want F/0010",
                  tap_state, ir);
      end
      checks++;
      if ({shift_dr, clk_dr, update_dr, mode, tdo_en, tdo} !== 6'b0) begin
         errors++;
         $display("FAIL rstmid_outs: got %b want 000000",
                  {shift_dr, clk_dr, update_dr, mode, tdo_en, tdo});
      end
      for (int i = 0; i < 2; i++) begin
         step(1, 0);
         checks++;
         if (update_dr !== 1'b0 || tap_state !== 4'hF) begin
            errors++;
            $display("FAIL rstmid_post_%0d: got %b/%h want 0/F",
                     i, update_dr, tap_state);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      tms = 1'b1;
      tdi = 1'b0;
      bsr_so = 1'b0;
      test_reset;
      test_walk;
      test_tlr_five;
      test_extest;
      test_idcode;
      test_bypass;
      test_sample;
      test_reset_mid_shift;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
